dac_controller: RTL and testbench

//   Output-side counterpart to the ADC front end: accepts per-channel words from the pid core
//   and writes them serially to an 8-channel 16-bit DAC (DAC8568-style 32-bit frames).

---
 rtl/dac_controller_if.sv | 40 ++++
 rtl/dac_controller.sv | 204 ++++++++++++++++++++
 tb/tb_dac_controller.sv | 283 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/dac_controller_if.sv
// dac_controller_if: pid-side write port plus DAC pin/status bundle.
// slave = controller side, master = pid core / DAC side.
interface dac_controller_if #(
  parameter int W_DATA = 16,
  parameter int W_CHAN = 3
);
  logic              dv_in;
  logic [W_CHAN-1:0] chan_in;
  logic [W_DATA-1:0] data_in;
  logic              nsync_out;
  logic              sclk_out;
  logic              din_out;
  logic              busy_out;
  logic              done_out;
  logic [W_CHAN-1:0] done_chan_out;

  modport master (
    output dv_in,
    output chan_in,
    output data_in,
    input  nsync_out,
    input  sclk_out,
    input  din_out,
    input  busy_out,
    input  done_out,
    input  done_chan_out
  );

  modport slave (
    input  dv_in,
    input  chan_in,
    input  data_in,
    output nsync_out,
    output sclk_out,
    output din_out,
    output busy_out,
    output done_out,
    output done_chan_out
  );
endinterface

// File: rtl/dac_controller.sv
// dac_controller: buffers latest word per channel, sends pending channels
// round-robin as 32-bit DAC8568 write+update frames, MSB first.
// Ports: clk_in, reset_in (sync, active high), bus (slave):
//   dv_in/chan_in/data_in in; nsync/sclk/din/busy/done/done_chan out.
// Option: DAC_INTREF_EN sends an internal-reference enable frame
//   (32'h0800_0001) after every reset before normal operation.
module dac_controller #(
  parameter int W_DATA     = 16,
  parameter int N_CHAN     = 8,
  parameter int W_CHAN     = 3,
  parameter int GAP_CYCLES = 2
) (
  input  logic             clk_in,
  input  logic             reset_in,
  dac_controller_if.slave  bus
);

  localparam int W_FRAME = 32;
  localparam int W_BIT   = 5;
  localparam int W_GAP   = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

`ifdef DAC_INTREF_EN
  localparam logic [W_FRAME-1:0] INIT_FRAME = 32'h0800_0001;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_SHIFT,
    ST_GAP,
    ST_INIT
  } state_t;

  localparam state_t ST_RESET = ST_INIT;
`else
  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_SHIFT,
    ST_GAP
  } state_t;

  localparam state_t ST_RESET = ST_IDLE;
`endif

  state_t             state_q, state_d;
  logic [N_CHAN-1:0]  pending_q, pending_d;
  logic [W_DATA-1:0]  buf_q [N_CHAN];
  logic [W_DATA-1:0]  buf_d [N_CHAN];
  logic [W_FRAME-1:0] shift_q, shift_d;
  logic [W_BIT-1:0]   bit_q, bit_d;
  logic [W_GAP-1:0]   gap_q, gap_d;
  logic [W_CHAN-1:0]  rr_q, rr_d;
  logic               nsync_q, nsync_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic [W_CHAN-1:0]  done_chan_q, done_chan_d;
  logic [W_CHAN-1:0]  cur_chan_q, cur_chan_d;
  logic               data_frame_q, data_frame_d;

  logic               found;
  logic [W_CHAN-1:0]  pick;
  logic [W_CHAN:0]    idx;
  logic [W_FRAME-1:0] frame;
  logic               wr_ok;

  // first pending channel at or after rr, wrapping
  always_comb begin
    found = 1'b0;
    pick  = '0;
    idx   = '0;
    for (int i = 0; i < N_CHAN; i++) begin
      idx = {1'b0, rr_q} + (W_CHAN+1)'(i);
      if (idx >= (W_CHAN+1)'(N_CHAN))
        idx = idx - (W_CHAN+1)'(N_CHAN);
      if (!found && pending_q[idx[W_CHAN-1:0]]) begin
        found = 1'b1;
        pick  = idx[W_CHAN-1:0];
      end
    end
  end

  assign frame = {4'b0000, 4'b0011, 4'(pick),
                  buf_q[pick], 4'b0000};

  assign wr_ok = bus.dv_in &&
    ({1'b0, bus.chan_in} < (W_CHAN+1)'(N_CHAN));

  always_comb begin
    state_d      = state_q;
    pending_d    = pending_q;
    buf_d        = buf_q;
    shift_d      = shift_q;
    bit_d        = bit_q;
    gap_d        = gap_q;
    rr_d         = rr_q;
    nsync_d      = nsync_q;
    done_d       = 1'b0;
    done_chan_d  = done_chan_q;
    cur_chan_d   = cur_chan_q;
    data_frame_d = data_frame_q;

    unique case (state_q)
      ST_IDLE: begin
        if (|pending_q)
          state_d = ST_LOAD;
      end
      ST_LOAD: begin
        if (found) begin
          shift_d        = frame;
          bit_d          = W_BIT'(W_FRAME-1);
          nsync_d        = 1'b0;
          pending_d[pick] = 1'b0;
          rr_d = (pick == W_CHAN'(N_CHAN-1)) ?
                 '0 : pick + 1'b1;
          cur_chan_d     = pick;
          data_frame_d   = 1'b1;
          state_d        = ST_SHIFT;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_SHIFT: begin
        // the register empties as it shifts, so din idles low
        shift_d = shift_q << 1;
        if (bit_q == '0) begin
          nsync_d = 1'b1;
          gap_d   = W_GAP'(GAP_CYCLES-1);
          state_d = ST_GAP;
        end else begin
          bit_d = bit_q - 1'b1;
          if (bit_q == W_BIT'(1) && data_frame_q) begin
            done_d      = 1'b1;
            done_chan_d = cur_chan_q;
          end
        end
      end
      ST_GAP: begin
        if (gap_q == '0)
          state_d = (|pending_q) ? ST_LOAD : ST_IDLE;
        else
          gap_d = gap_q - 1'b1;
      end
`ifdef DAC_INTREF_EN
      ST_INIT: begin
        shift_d      = INIT_FRAME;
        bit_d        = W_BIT'(W_FRAME-1);
        nsync_d      = 1'b0;
        data_frame_d = 1'b0;
        state_d      = ST_SHIFT;
      end
`endif
      default: state_d = ST_IDLE;
    endcase

    // a write landing on the LOAD edge re-sets the bit: set wins
    if (wr_ok) begin
      pending_d[bus.chan_in] = 1'b1;
      buf_d[bus.chan_in]     = bus.data_in;
    end

    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk_in) begin
    if (reset_in) begin
      state_q      <= ST_RESET;
      pending_q    <= '0;
      buf_q        <= '{default: '0};
      shift_q      <= '0;
      bit_q        <= '0;
      gap_q        <= '0;
      rr_q         <= '0;
      nsync_q      <= 1'b1;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      done_chan_q  <= '0;
      cur_chan_q   <= '0;
      data_frame_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      pending_q    <= pending_d;
      buf_q        <= buf_d;
      shift_q      <= shift_d;
      bit_q        <= bit_d;
      gap_q        <= gap_d;
      rr_q         <= rr_d;
      nsync_q      <= nsync_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      done_chan_q  <= done_chan_d;
      cur_chan_q   <= cur_chan_d;
      data_frame_q <= data_frame_d;
    end
  end

  // sclk falls mid-bit (clk_in low phase) while din is stable
  assign bus.sclk_out      = nsync_q | clk_in;
  assign bus.nsync_out     = nsync_q;
  assign bus.din_out       = shift_q[W_FRAME-1];
  assign bus.busy_out      = busy_q;
  assign bus.done_out      = done_q;
  assign bus.done_chan_out = done_chan_q;

endmodule

// File: tb/tb_dac_controller.sv
// tb_dac_controller: random + directed stimulus, frames decoded
// from the pins and compared with a per-channel buffer model.
module tb_dac_controller;
  localparam int W_DATA     = 16;
  localparam int N_CHAN     = 8;
  localparam int W_CHAN     = 3;
  localparam int GAP_CYCLES = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  dac_controller_if #(
    .W_DATA(W_DATA),
    .W_CHAN(W_CHAN)
  ) bus ();

  dac_controller #(
    .W_DATA    (W_DATA),
    .N_CHAN    (N_CHAN),
    .W_CHAN    (W_CHAN),
    .GAP_CYCLES(GAP_CYCLES)
  ) dut (
    .clk_in  (clk),
    .reset_in(rst),
    .bus     (bus.slave)
  );

  typedef struct {
    logic [31:0] frame;
    logic        has_done;
    logic [2:0]  chan;
  } exp_t;

  int total = 0;
  int bad   = 0;

  exp_t        exp_q[$];
  logic [7:0]  m_pend;
  logic [15:0] m_buf [N_CHAN];
  int          m_rr;
  bit          m_init;
  bit          prev_nsync;
  int          bits;
  logic [31:0] rx;
  int          hi_run;
  bit          seen_frame;
  int          frames;
  logic [31:0] last_frame;
  int          chan_log[$];

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h t=%0t",
               tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    exp_t e;
    m_pend     = '0;
    for (int i = 0; i < N_CHAN; i++) m_buf[i] = '0;
    m_rr       = 0;
    exp_q.delete();
    bits       = 0;
    prev_nsync = 1'b1;
    hi_run     = 0;
    seen_frame = 1'b0;
    m_init     = 1'b0;
`ifdef DAC_INTREF_EN
    m_init     = 1'b1;
    e.frame    = 32'h0800_0001;
    e.has_done = 1'b0;
    e.chan     = '0;
    exp_q.push_back(e);
`endif
  endtask

  task automatic pick_model();
    exp_t e;
    int c;
    c = -1;
    for (int i = 0; i < N_CHAN; i++) begin
      int k;
      k = (m_rr + i) % N_CHAN;
      if (c < 0 && m_pend[k]) c = k;
    end
    if (c < 0) begin
      check("spurious_frame", 32'd1, 32'd0);
      return;
    end
    m_pend[c]  = 1'b0;
    m_rr       = (c + 1) % N_CHAN;
    e.frame    = (32'h3 << 24) | (32'(c) << 20)
               | (32'(m_buf[c]) << 4);
    e.has_done = 1'b1;
    e.chan     = 3'(c);
    exp_q.push_back(e);
  endtask

  task automatic step(input bit r, input bit dv,
                      input int ch,
                      input logic [15:0] d);
    exp_t e;
    rst         = r;
    bus.dv_in   = dv;
    bus.chan_in = 3'(ch);
    bus.data_in = d;
    @(posedge clk);
    @(negedge clk);
    if (r) begin
      model_reset();
      check("rst_nsync", 32'(bus.nsync_out), 32'd1);
      check("rst_busy", 32'(bus.busy_out), 32'd0);
      check("rst_done", 32'(bus.done_out), 32'd0);
      check("rst_dchan", 32'(bus.done_chan_out), 32'd0);
      check("rst_din", 32'(bus.din_out), 32'd0);
      return;
    end
    // frame start: choice made from state before this edge's write
    if (prev_nsync && !bus.nsync_out) begin
      if (seen_frame)
        check("gap", 32'(hi_run >= GAP_CYCLES), 32'd1);
      if (m_init) m_init = 1'b0;
      else pick_model();
      bits = 0;
    end
    if (dv && ch < N_CHAN) begin
      m_pend[ch] = 1'b1;
      m_buf[ch]  = d;
    end
    if (!bus.nsync_out) begin
      hi_run = 0;
      rx     = {rx[30:0], bus.din_out};
      bits++;
      check("busy_frame", 32'(bus.busy_out), 32'd1);
      if (bits == 32) begin
        bits = 0;
        if (exp_q.size() == 0) begin
          check("unexpected_frame", 32'd1, 32'd0);
        end else begin
          e = exp_q.pop_front();
          check("frame", rx, e.frame);
          check("done_last", 32'(bus.done_out),
                32'(e.has_done));
          if (e.has_done) begin
            check("done_chan", 32'(bus.done_chan_out),
                  32'(e.chan));
            chan_log.push_back(int'(e.chan));
          end
          frames++;
          seen_frame = 1'b1;
          last_frame = rx;
        end
      end else begin
        check("done_mid", 32'(bus.done_out), 32'd0);
      end
    end else begin
      hi_run++;
      check("done_idle", 32'(bus.done_out), 32'd0);
      if (bits != 0) begin
        check("frame_len", 32'(bits), 32'd32);
        bits = 0;
      end
    end
    prev_nsync = bus.nsync_out;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, '0);
  endtask

  task automatic wait_idle(input int bound);
    for (int i = 0; i < bound; i++) begin
      if (!bus.busy_out && bus.nsync_out && bits == 0
          && exp_q.size() == 0 && m_pend == '0)
        return;
      step(0, 0, 0, '0);
    end
    check("wait_idle_timeout", 32'd0, 32'd1);
  endtask

  int f0;
  int init_frames;

  initial begin
    frames = 0;
    last_frame = '0;
    rx = '0;
`ifdef DAC_INTREF_EN
    init_frames = 1;
`else
    init_frames = 0;
`endif

    // 1: single write, latency and frame content
    step(1, 0, 0, '0);
    wait_idle(200);
    step(0, 1, 2, 16'hABCD);
    check("lat_k1", 32'(bus.nsync_out), 32'd1);
    step(0, 0, 0, '0);
    check("lat_k2_hi", 32'(bus.nsync_out), 32'd1);
    step(0, 0, 0, '0);
    check("lat_k2", 32'(bus.nsync_out), 32'd0);
    wait_idle(200);
    check("t1_frame", last_frame, 32'h032A_BCD0);

    // 2: rewrite before send, latest value wins
    f0 = frames;
    step(0, 1, 0, 16'h5555);
    idle(6);
    step(0, 1, 5, 16'h1111);
    idle(3);
    step(0, 1, 5, 16'h2222);
    wait_idle(300);
    check("t2_count", 32'(frames - f0), 32'd2);
    check("t2_frame", last_frame, 32'h0352_2220);

    // 3: round-robin order from rr=4
    step(1, 0, 0, '0);
    step(0, 1, 3, 16'h0033);
    wait_idle(300);
    chan_log.delete();
    step(0, 1, 7, 16'h0777);
    step(0, 1, 1, 16'h0111);
    step(0, 1, 3, 16'h0333);
    wait_idle(400);
    check("t3_n", 32'(chan_log.size()), 32'd3);
    if (chan_log.size() == 3) begin
      check("t3_o0", 32'(chan_log[0]), 32'd7);
      check("t3_o1", 32'(chan_log[1]), 32'd1);
      check("t3_o2", 32'(chan_log[2]), 32'd3);
    end

    // 4: write on the LOAD edge of the same channel
    step(1, 0, 0, '0);
    wait_idle(200);
    f0 = frames;
    step(0, 1, 4, 16'h0000);
    step(0, 0, 0, '0);
    step(0, 1, 4, 16'h0001);
    wait_idle(300);
    check("t4_count", 32'(frames - f0), 32'd2);
    check("t4_frame", last_frame, 32'h0340_0010);

    // 5: reset mid-frame drops everything
    step(1, 0, 0, '0);
    wait_idle(200);
    step(0, 1, 0, 16'h1234);
    step(0, 1, 1, 16'h2345);
    step(0, 1, 2, 16'h3456);
    step(0, 1, 3, 16'h4567);
    for (int i = 0; i < 60 && bits != 10; i++)
      step(0, 0, 0, '0);
    check("t5_bit10", 32'(bits), 32'd10);
    f0 = frames;
    step(1, 0, 0, '0);
    idle(120);
    check("t5_frames", 32'(frames - f0),
          32'(init_frames));
    check("t5_busy", 32'(bus.busy_out), 32'd0);

    // random traffic with occasional reset
    step(1, 0, 0, '0);
    for (int i = 0; i < 3000; i++) begin
      step($urandom_range(0, 799) == 0,
           $urandom_range(0, 3) == 0,
           int'($urandom_range(0, N_CHAN-1)),
           16'($urandom));
    end
    wait_idle(2000);
    check("end_queue", 32'(exp_q.size()), 32'd0);
    check("end_pend", 32'(m_pend), 32'd0);
    check("end_busy", 32'(bus.busy_out), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
